// File: rtl/power_domain_scheduler.sv
`default_nettype none
// ---- power_domain_scheduler : per-domain 2^L clock dividers, glitch-free level change and gating ----
// ---- rev 1.0 ----
module power_domain_scheduler #(
  parameter int NUM_DOMAINS = 4,
  parameter int DOM_W       = 2,
  parameter int LEVEL_W     = 3,
  parameter int RESET_LEVEL = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           change_level_flag,
  input  logic [LEVEL_W-1:0]             change_level,
  input  logic                           change_power_mode_flag,
  input  logic                           change_power_mode,
  input  logic [DOM_W-1:0]               change_domain,
  output logic [NUM_DOMAINS-1:0]         power_domain_clk,
  output logic [NUM_DOMAINS-1:0]         domain_busy,
  output logic [NUM_DOMAINS-1:0]         domain_gated,
  output logic [NUM_DOMAINS*LEVEL_W-1:0] level_status,
  output logic                           change_error
);

  // Counter must reach 2^Lmax - 1 where Lmax = 2^LEVEL_W - 1.
  localparam int CNT_W = (1 << LEVEL_W) - 1;

  logic [NUM_DOMAINS-1:0] w_hit;
  logic                   w_in_range;
  logic                   w_target_busy;
  logic                   w_accept_level;
  logic                   w_accept_mode;
  logic                   w_reject;
  logic                   r_error;

  assign w_in_range     = (32'(change_domain) < 32'(NUM_DOMAINS));
  assign w_target_busy  = |(w_hit & domain_busy);
  assign w_accept_level = change_level_flag && w_in_range && !w_target_busy;
  // A simultaneous level request always wins; the mode request is then rejected.
  assign w_accept_mode  = change_power_mode_flag && !change_level_flag
                          && w_in_range && !w_target_busy;
  assign w_reject       = (change_level_flag && !w_accept_level)
                          || (change_power_mode_flag && !w_accept_mode);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else begin
      r_error <= w_reject;
    end
  end

  assign change_error = r_error;

  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
    logic [CNT_W-1:0]   r_cnt;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] r_pend_level;
    logic               r_q;
    logic               r_busy;
    logic               r_gated;
    logic               r_pend_is_mode;
    logic               r_pend_mode;
    logic [CNT_W:0]     w_limit;
    logic               w_at_edge;
    logic               w_apply_point;
    logic               w_load;

    assign w_hit[d]      = (32'(change_domain) == 32'(d));
    assign w_limit       = ((CNT_W+1)'(1) << r_level) - (CNT_W+1)'(1);
    assign w_at_edge     = ({1'b0, r_cnt} == w_limit);
    // Changes land only at the end of a low phase so the output never runts.
    assign w_apply_point = !r_q && w_at_edge && !r_gated;
    assign w_load        = w_hit[d] && (w_accept_level || w_accept_mode);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt          <= '0;
        r_level        <= LEVEL_W'(RESET_LEVEL);
        r_pend_level   <= '0;
        r_q            <= 1'b0;
        r_busy         <= 1'b0;
        r_gated        <= 1'b0;
        r_pend_is_mode <= 1'b0;
        r_pend_mode    <= 1'b0;
      end else begin
        if (!r_gated) begin
          if (w_at_edge) begin
            r_q   <= ~r_q;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        if (r_busy) begin
          if (!r_pend_is_mode) begin
            if (r_gated) begin
              r_level <= r_pend_level;
              r_busy  <= 1'b0;
            end else if (w_apply_point) begin
              r_level <= r_pend_level;
              r_cnt   <= '0;
              r_q     <= 1'b0;
              r_busy  <= 1'b0;
            end
          end else if (r_pend_mode) begin
            if (r_gated) begin
              r_busy <= 1'b0;
            end else if (w_apply_point) begin
              r_q     <= 1'b0;
              r_cnt   <= '0;
              r_gated <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            // Ungating an already running domain leaves its phase untouched.
            if (r_gated) begin
              r_gated <= 1'b0;
              r_cnt   <= '0;
              r_q     <= 1'b0;
            end
            r_busy <= 1'b0;
          end
        end

        if (w_load) begin
          r_busy         <= 1'b1;
          r_pend_is_mode <= w_accept_mode;
          r_pend_mode    <= change_power_mode;
          r_pend_level   <= change_level;
        end
      end
    end

    assign power_domain_clk[d]                 = r_q;
    assign domain_busy[d]                      = r_busy;
    assign domain_gated[d]                     = r_gated;
    assign level_status[d*LEVEL_W +: LEVEL_W]  = r_level;
  end

endmodule
`default_nettype wire

// File: tb/tb_power_domain_scheduler.sv
`default_nettype none
// ---- tb_power_domain_scheduler : scenario tasks with a queue of expected values ----
// ---- rev 1.0 ----
module tb_power_domain_scheduler;

  logic        clk;
  logic        reset;
  logic        change_level_flag;
  logic [2:0]  change_level;
  logic        change_power_mode_flag;
  logic        change_power_mode;
  logic [2:0]  change_domain;
  logic [3:0]  power_domain_clk;
  logic [3:0]  domain_busy;
  logic [3:0]  domain_gated;
  logic [11:0] level_status;
  logic        change_error;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  power_domain_scheduler #(
    .NUM_DOMAINS(4),
    .DOM_W      (3),
    .LEVEL_W    (3),
    .RESET_LEVEL(0)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .change_level_flag     (change_level_flag),
    .change_level          (change_level),
    .change_power_mode_flag(change_power_mode_flag),
    .change_power_mode     (change_power_mode),
    .change_domain         (change_domain),
    .power_domain_clk      (power_domain_clk),
    .domain_busy           (domain_busy),
    .domain_gated          (domain_gated),
    .level_status          (level_status),
    .change_error          (change_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    change_level_flag      = 1'b0;
    change_power_mode_flag = 1'b0;
  endtask

  task automatic wait_busy(input int d, output int n);
    n = 0;
    while (domain_busy[d] !== 1'b0 && n < 64) begin
      step();
      n++;
    end
    if (domain_busy[d] !== 1'b0) n = -1;
  endtask

  task automatic wait_change(input int d, output int n);
    logic v;
    v = power_domain_clk[d];
    n = 0;
    do begin
      step();
      n++;
    end while (power_domain_clk[d] === v && n < 64);
    if (power_domain_clk[d] === v) n = -1;
  endtask

  task automatic test_reset();
    int e;
    reset = 1'b0;
    idle();
    change_level = 3'd0; change_power_mode = 1'b0; change_domain = 3'd0;
    repeat (3) step();
    total++; if (power_domain_clk !== 4'h0) begin bad++; $display("FAIL reset_clk got=%h want=0", power_domain_clk); end
    total++; if (domain_busy !== 4'h0) begin bad++; $display("FAIL reset_busy got=%h want=0", domain_busy); end
    total++; if (domain_gated !== 4'h0) begin bad++; $display("FAIL reset_gated got=%h want=0", domain_gated); end
    total++; if (change_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", change_error); end
    total++; if (level_status !== 12'h000) begin bad++; $display("FAIL reset_level got=%h want=000", level_status); end
    exp_q.push_back(4'hF); exp_q.push_back(4'h0); exp_q.push_back(4'hF); exp_q.push_back(4'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      e = exp_q.pop_front();
      total++; if (power_domain_clk !== e[3:0]) begin bad++; $display("FAIL release_clk cyc=%0d got=%h want=%h", i, power_domain_clk, e[3:0]); end
    end
  endtask

  task automatic test_level_change();
    int n;
    int e;
    n = 0;
    while (power_domain_clk[1] !== 1'b1 && n < 10) begin step(); n++; end
    change_level_flag = 1'b1; change_level = 3'd2; change_domain = 3'd1;
    exp_q.push_back(5); exp_q.push_back(4); exp_q.push_back(4);
    step();
    idle();
    total++; if (domain_busy[1] !== 1'b1) begin bad++; $display("FAIL lvl_busy_set got=%b want=1", domain_busy[1]); end
    total++; if (power_domain_clk[1] !== 1'b0) begin bad++; $display("FAIL lvl_fall got=%b want=0", power_domain_clk[1]); end
    step();
    total++; if (domain_busy[1] !== 1'b0) begin bad++; $display("FAIL lvl_busy_clr got=%b want=0", domain_busy[1]); end
    total++; if (level_status[5:3] !== 3'd2) begin bad++; $display("FAIL lvl_status got=%0d want=2", level_status[5:3]); end
    wait_change(1, n);
    e = exp_q.pop_front();
    total++; if ((n < 0 ? 0 : n + 1) != e) begin bad++; $display("FAIL lvl_low_phase got=%0d want=%0d", (n < 0 ? 0 : n + 1), e); end
    for (int k = 0; k < 2; k++) begin
      wait_change(1, n);
      e = exp_q.pop_front();
      total++; if (n != e) begin bad++; $display("FAIL lvl_half_period k=%0d got=%0d want=%0d", k, n, e); end
    end
    total++; if ({power_domain_clk[0], power_domain_clk[2]} !== {2{power_domain_clk[3]}}) begin bad++; $display("FAIL lvl_others_phase got=%h want=in-phase", power_domain_clk); end
    e = power_domain_clk[0];
    step();
    total++; if (power_domain_clk[0] === e[0]) begin bad++; $display("FAIL lvl_others_toggle got=%b want=%b", power_domain_clk[0], ~e[0]); end
  endtask

  task automatic test_errors();
    int n;
    change_level_flag = 1'b1; change_level = 3'd2; change_domain = 3'd1;
    step();
    change_level = 3'd5;
    total++; if (domain_busy[1] !== 1'b1) begin bad++; $display("FAIL err_first_busy got=%b want=1", domain_busy[1]); end
    total++; if (change_error !== 1'b0) begin bad++; $display("FAIL err_first_ok got=%b want=0", change_error); end
    step();
    idle();
    total++; if (change_error !== 1'b1) begin bad++; $display("FAIL err_busy_pulse got=%b want=1", change_error); end
    step();
    total++; if (change_error !== 1'b0) begin bad++; $display("FAIL err_busy_single got=%b want=0", change_error); end
    wait_busy(1, n);
    total++; if (n < 0) begin bad++; $display("FAIL err_busy_timeout got=busy want=idle"); end
    total++; if (level_status[5:3] !== 3'd2) begin bad++; $display("FAIL err_level_kept got=%0d want=2", level_status[5:3]); end
    change_level_flag = 1'b1; change_level = 3'd1; change_domain = 3'd4;
    step();
    idle();
    total++; if (change_error !== 1'b1) begin bad++; $display("FAIL err_range_pulse got=%b want=1", change_error); end
    total++; if (domain_busy !== 4'h0) begin bad++; $display("FAIL err_range_busy got=%h want=0", domain_busy); end
    step();
    total++; if (change_error !== 1'b0) begin bad++; $display("FAIL err_range_single got=%b want=0", change_error); end
    total++; if (level_status !== 12'h010) begin bad++; $display("FAIL err_range_state got=%h want=010", level_status); end
  endtask

  task automatic test_gate();
    int n;
    int toggles;
    int e;
    change_level_flag = 1'b1; change_level = 3'd1; change_domain = 3'd2;
    step();
    idle();
    wait_busy(2, n);
    total++; if (level_status[8:6] !== 3'd1) begin bad++; $display("FAIL gate_lvl got=%0d want=1", level_status[8:6]); end
    change_power_mode_flag = 1'b1; change_power_mode = 1'b1; change_domain = 3'd2;
    step();
    idle();
    total++; if (domain_busy[2] !== 1'b1) begin bad++; $display("FAIL gate_busy got=%b want=1", domain_busy[2]); end
    wait_busy(2, n);
    total++; if (n < 0) begin bad++; $display("FAIL gate_timeout got=busy want=idle"); end
    total++; if (domain_gated[2] !== 1'b1) begin bad++; $display("FAIL gate_flag got=%b want=1", domain_gated[2]); end
    toggles = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (power_domain_clk[2] !== 1'b0) toggles++;
    end
    total++; if (toggles != 0) begin bad++; $display("FAIL gate_held_low got=%0d want=0", toggles); end
    change_power_mode_flag = 1'b1; change_power_mode = 1'b0;
    exp_q.push_back(2);
    step();
    idle();
    total++; if (domain_gated[2] !== 1'b1) begin bad++; $display("FAIL ungate_pending got=%b want=1", domain_gated[2]); end
    step();
    total++; if (domain_gated[2] !== 1'b0) begin bad++; $display("FAIL ungate_flag got=%b want=0", domain_gated[2]); end
    wait_change(2, n);
    e = exp_q.pop_front();
    total++; if (n != e) begin bad++; $display("FAIL ungate_first_rise got=%0d want=%0d", n, e); end
    total++; if (power_domain_clk[2] !== 1'b1) begin bad++; $display("FAIL ungate_rise_dir got=%b want=1", power_domain_clk[2]); end
  endtask

  task automatic test_both_flags();
    int n;
    change_level_flag = 1'b1; change_level = 3'd1;
    change_power_mode_flag = 1'b1; change_power_mode = 1'b1; change_domain = 3'd0;
    step();
    idle();
    total++; if (change_error !== 1'b1) begin bad++; $display("FAIL both_error got=%b want=1", change_error); end
    total++; if (domain_busy[0] !== 1'b1) begin bad++; $display("FAIL both_busy got=%b want=1", domain_busy[0]); end
    step();
    total++; if (change_error !== 1'b0) begin bad++; $display("FAIL both_error_single got=%b want=0", change_error); end
    wait_busy(0, n);
    total++; if (domain_gated[0] !== 1'b0) begin bad++; $display("FAIL both_not_gated got=%b want=0", domain_gated[0]); end
    total++; if (level_status[2:0] !== 3'd1) begin bad++; $display("FAIL both_level got=%0d want=1", level_status[2:0]); end
  endtask

  task automatic test_reset_mid();
    int e;
    change_level_flag = 1'b1; change_level = 3'd3; change_domain = 3'd3;
    step();
    idle();
    total++; if (domain_busy[3] !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", domain_busy[3]); end
    #2 reset = 1'b0;
    #1;
    total++; if ({power_domain_clk, domain_busy, domain_gated, change_error} !== 13'h0) begin bad++; $display("FAIL mid_async got=%h want=0", {power_domain_clk, domain_busy, domain_gated, change_error}); end
    total++; if (level_status !== 12'h000) begin bad++; $display("FAIL mid_level got=%h want=000", level_status); end
    change_level_flag = 1'b1; change_level = 3'd4; change_domain = 3'd3;
    step();
    step();
    idle();
    total++; if (domain_busy !== 4'h0) begin bad++; $display("FAIL mid_ignore got=%h want=0", domain_busy); end
    exp_q.push_back(4'hF); exp_q.push_back(4'h0); exp_q.push_back(4'hF);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_q.pop_front();
      total++; if (power_domain_clk !== e[3:0]) begin bad++; $display("FAIL mid_release cyc=%0d got=%h want=%h", i, power_domain_clk, e[3:0]); end
    end
    total++; if (level_status[11:9] !== 3'd0) begin bad++; $display("FAIL mid_dom3_level got=%0d want=0", level_status[11:9]); end
  endtask

  initial begin
    test_reset();
    test_level_change();
    test_errors();
    test_gate();
    test_both_flags();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
